// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Row and column counts, key code type, FSM states and the idle column pattern.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;
  typedef logic [1:0] idx_t;

  localparam logic [COLS-1:0] COL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD
  } state_t;

  // Lowest-numbered low column wins when several keys share a row.
  function automatic idx_t first_low(input logic [COLS-1:0] cols);
    first_low = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!cols[i]) first_low = idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle; master is the scanner, slave is the keypad/consumer side.
// No backpressure: key_valid is a fire-and-forget strobe.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  key_code_t       key_code;
  logic            key_valid;
  logic            key_held;

  modport master (input col_n, output row_n, key_code, key_valid, key_held);
  modport slave  (output col_n, input row_n, key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_slot_timer.sv
// Free-running 0..SCAN_DIV-1 counter; tick is high on the last cycle of each slot.
// Latency: tick is combinational from the count; no backpressure.
module keypad_slot_timer #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with built-in press/release debounce; key_valid strobes one cycle after acceptance.
// No backpressure. Optional auto-repeat strobes while held when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV         = 1000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_SAMPLES   = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kp
);

  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SAMPLES - 1);

  if (DEBOUNCE_SAMPLES < 1 || REPEAT_SAMPLES < 1 || SCAN_DIV < 1) begin : g_bad_cfg
    $error("keypad_scanner: SCAN_DIV, DEBOUNCE_SAMPLES and REPEAT_SAMPLES must be >= 1");
  end

  logic [COLS-1:0] col_meta, csync;
  logic            tick;

  state_t          state_q, state_d;
  idx_t            row_q, row_d, col_q, col_d;
  logic [CW-1:0]   match_q, match_d, rel_q, rel_d;
  key_code_t       code_q, code_d;
  logic            valid_q, valid_d, held_q, held_d;
  logic            accept;
  idx_t            acc_col;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SAMPLES + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_SAMPLES - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  keypad_slot_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= COL_IDLE;
      csync    <= COL_IDLE;
      state_q  <= SCAN;
      row_q    <= '0;
      col_q    <= '0;
      match_q  <= '0;
      rel_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      col_meta <= kp.col_n;
      csync    <= col_meta;
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      match_q  <= match_d;
      rel_q    <= rel_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    match_d = match_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    accept  = 1'b0;
    acc_col = col_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (csync == COL_IDLE) begin
            row_d = row_q + 1'b1;
          end else begin
            col_d   = first_low(csync);
            acc_col = first_low(csync);
            if (DEBOUNCE_SAMPLES == 1) begin
              accept = 1'b1;
            end else begin
              match_d = CW'(1);
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (!csync[col_q]) begin
            if (match_q == DB_LAST) accept  = 1'b1;
            else                    match_d = match_q + 1'b1;
          end else begin
            match_d = '0;
            state_d = SCAN;
            row_d   = row_q + 1'b1;
          end
        end
        HELD: begin
          if (csync == COL_IDLE) begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
            if (rel_q == DB_LAST) begin
              rel_d   = '0;
              held_d  = 1'b0;
              state_d = SCAN;
              row_d   = row_q + 1'b1;
            end else begin
              rel_d = rel_q + 1'b1;
            end
          end else begin
            // Any low column (including a second key) only cancels release progress.
            rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if (!csync[col_q]) begin
              if (rep_q == RP_LAST) begin
                valid_d = 1'b1;
                rep_d   = '0;
              end else begin
                rep_d = rep_q + 1'b1;
              end
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end

    if (accept) begin
      code_d  = {row_q, acc_col};
      valid_d = 1'b1;
      held_d  = 1'b1;
      match_d = '0;
      rel_d   = '0;
      state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = '0;
`endif
    end
  end

  assign kp.row_n     = ~(ROWS'(1) << row_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule
